// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus widths, bus field offsets, mem_size codes and alu_op bit indices for the EX stage
package exe_stage_pkg;
  localparam int DS_TO_ES_BUS_WD = 151;
  localparam int ES_TO_MS_BUS_WD = 77;
  localparam int ES_FWD_BUS_WD   = 39;
  localparam int DS_PC_LSB    = 0;
  localparam int DS_RKD_LSB   = 32;
  localparam int DS_SIGN      = 64;
  localparam int DS_SIZE_LSB  = 65;
  localparam int DS_MEM_WE    = 67;
  localparam int DS_RFM       = 68;
  localparam int DS_GR_WE     = 69;
  localparam int DS_DEST_LSB  = 70;
  localparam int DS_SRC2_LSB  = 75;
  localparam int DS_SRC1_LSB  = 107;
  localparam int DS_OP_LSB    = 139;
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;
endpackage

// File: rtl/alu.sv
// alu: 12-op one-hot ALU (alu_op, alu_src1, alu_src2 in; alu_result out), lui passes src2
module alu
  import exe_stage_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_result
);
  logic [31:0] add_r, sub_r, sll_r, srl_r, sra_r;
  logic        slt_r, sltu_r;
  always_comb begin
    add_r  = alu_src1 + alu_src2;
    sub_r  = alu_src1 - alu_src2;
    slt_r  = $signed(alu_src1) < $signed(alu_src2);
    sltu_r = alu_src1 < alu_src2;
    sll_r  = alu_src1 << alu_src2[4:0];
    srl_r  = alu_src1 >> alu_src2[4:0];
    sra_r  = $signed(alu_src1) >>> alu_src2[4:0];
    alu_result = ({32{alu_op[ALU_ADD]}}  & add_r)
               | ({32{alu_op[ALU_SUB]}}  & sub_r)
               | ({32{alu_op[ALU_SLT]}}  & {31'd0, slt_r})
               | ({32{alu_op[ALU_SLTU]}} & {31'd0, sltu_r})
               | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
               | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
               | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
               | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
               | ({32{alu_op[ALU_SLL]}}  & sll_r)
               | ({32{alu_op[ALU_SRL]}}  & srl_r)
               | ({32{alu_op[ALU_SRA]}}  & sra_r)
               | ({32{alu_op[ALU_LUI]}}  & alu_src2);
  end
endmodule

// File: rtl/exe_stage_store_fmt.sv
// exe_stage_store_fmt: size/addr/rkd/we/rd -> raw byte enables, replicated write data, misalign flag
module exe_stage_store_fmt
  import exe_stage_pkg::*;
(
  input  logic [1:0]  mem_size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rkd_i,
  input  logic        mem_we_i,
  input  logic        mem_rd_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic        ale_o
);
  logic is_b, is_h, is_w;
  always_comb begin
    is_b    = mem_size_i == MEM_SIZE_B;
    is_h    = mem_size_i == MEM_SIZE_H;
    is_w    = !is_b && !is_h;
    we_o    = !mem_we_i ? 4'b0000 :
              is_b ? 4'b0001 << addr_lo_i :
              is_h ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = is_b ? {4{rkd_i[7:0]}} : is_h ? {2{rkd_i[15:0]}} : rkd_i;
    ale_o   = (mem_we_i || mem_rd_i) && ((is_h && addr_lo_i[0]) || (is_w && addr_lo_i != 2'b00));
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: EX stage; ID bus in via valid/allowin, MEM bus + data SRAM request + forwarding bus out
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_allowin,
  input  logic                       ms_allowin,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
  input  logic                       flush,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);
  logic                       es_valid_q, es_valid_d;
  logic [DS_TO_ES_BUS_WD-1:0] bus_q, bus_d;
  logic [11:0] alu_op;
  logic [31:0] src1, src2, rkd, pc, alu_result, fmt_wdata;
  logic [4:0]  dest;
  logic [1:0]  mem_size;
  logic [3:0]  fmt_we;
  logic        gr_we, rfm, mem_we, mem_sign, fmt_ale, es_ale, es_ready_go;
  assign alu_op   = bus_q[DS_OP_LSB +: 12];
  assign src1     = bus_q[DS_SRC1_LSB +: 32];
  assign src2     = bus_q[DS_SRC2_LSB +: 32];
  assign dest     = bus_q[DS_DEST_LSB +: 5];
  assign gr_we    = bus_q[DS_GR_WE];
  assign rfm      = bus_q[DS_RFM];
  assign mem_we   = bus_q[DS_MEM_WE];
  assign mem_size = bus_q[DS_SIZE_LSB +: 2];
  assign mem_sign = bus_q[DS_SIGN];
  assign rkd      = bus_q[DS_RKD_LSB +: 32];
  assign pc       = bus_q[DS_PC_LSB +: 32];
  alu u_alu (
    .alu_op    (alu_op),
    .alu_src1  (src1),
    .alu_src2  (src2),
    .alu_result(alu_result)
  );
  exe_stage_store_fmt u_fmt (
    .mem_size_i(mem_size),
    .addr_lo_i (alu_result[1:0]),
    .rkd_i     (rkd),
    .mem_we_i  (mem_we),
    .mem_rd_i  (rfm),
    .we_o      (fmt_we),
    .wdata_o   (fmt_wdata),
    .ale_o     (fmt_ale)
  );
  always_comb begin
    es_ready_go     = 1'b1;
    es_allowin      = !es_valid_q || (es_ready_go && ms_allowin);
    es_to_ms_valid  = es_valid_q && es_ready_go && !flush;
    es_valid_d      = flush ? 1'b0 : es_allowin ? ds_to_es_valid : es_valid_q;
    bus_d           = (ds_to_es_valid && es_allowin && !flush) ? ds_to_es_bus : bus_q;
    es_ale          = es_valid_q && fmt_ale;
    data_sram_en    = es_valid_q && (rfm || mem_we) && ms_allowin && !flush && !fmt_ale;
    data_sram_we    = data_sram_en ? fmt_we : 4'b0000;
    data_sram_addr  = alu_result;
    data_sram_wdata = fmt_wdata;
    es_to_ms_bus    = {pc, alu_result, dest, gr_we, rfm, mem_size, mem_sign, alu_result[1:0], es_ale};
    es_fwd_bus      = {es_valid_q && gr_we && dest != 5'd0, rfm, dest, alu_result};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      bus_q      <= bus_d;
    end
  end
endmodule
